// File: rtl/axi_id_tracker.sv
// axi_id_tracker
//   Initiator-side write tracker. Accepts one upstream write request at a time,
//   obtains an AXI ID from axi_id_pool, issues the AW beat with it, and keeps a
//   bitmap of outstanding IDs. Each B response retires its ID, returns it to the
//   pool via dealloc and reports completion on resp_*.
//
// Ports
//   clk, reset_n              clock (rising edge), async active-low reset
//   txn_valid/ready/addr      upstream write request
//   alloc_req/valid/id        ID request to the pool and its grant
//   dealloc_req/id            one-cycle pulse returning a retired ID to the pool
//   awvalid/ready/id/addr     AXI AW channel
//   bvalid/ready/id/resp      AXI B channel
//   resp_valid/id/err         one-cycle pulse per retired transaction
//   outstanding               number of IDs currently in flight
//   err_bid                   sticky: B seen for an ID that was not outstanding
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | ready for a new request if below the outstanding cap
// S_ALLOC | request latched, waiting for the pool to grant an ID
// S_ADDR  | AW beat presented, held stable until awready

module axi_id_tracker #(
    parameter int ID_WIDTH        = 4,
    parameter int ID_COUNT        = 1 << ID_WIDTH,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = ID_COUNT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  txn_valid,
    output logic                  txn_ready,
    input  logic [ADDR_WIDTH-1:0] txn_addr,
    output logic                  alloc_req,
    input  logic                  alloc_valid,
    input  logic [ID_WIDTH-1:0]   alloc_id,
    output logic                  dealloc_req,
    output logic [ID_WIDTH-1:0]   dealloc_id,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ID_WIDTH-1:0]   awid,
    output logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  bvalid,
    output logic                  bready,
    input  logic [ID_WIDTH-1:0]   bid,
    input  logic [1:0]            bresp,
    output logic                  resp_valid,
    output logic [ID_WIDTH-1:0]   resp_id,
    output logic                  resp_err,
    output logic [ID_WIDTH:0]     outstanding,
    output logic                  err_bid
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALLOC = 2'd1,
        S_ADDR  = 2'd2
    } state_t;

    localparam logic [ID_WIDTH:0] MAX_CNT = (ID_WIDTH+1)'(MAX_OUTSTANDING);

    state_t                state;
    logic [ID_COUNT-1:0]   bitmap;
    logic [ID_COUNT-1:0]   bitmap_nxt;
    logic [ID_COUNT-1:0]   set_mask;
    logic [ID_COUNT-1:0]   clr_mask;
    logic [ID_WIDTH:0]     outstanding_nxt;
    logic                  aw_fire;
    logic                  b_fire;
    logic                  b_hit;

    // B is always accepted while out of reset; gating with reset_n keeps every
    // output low during reset and lets txn_ready rise as soon as it releases.
    assign bready    = reset_n;
    assign txn_ready = reset_n && (state == S_IDLE) && (outstanding < MAX_CNT);

    assign aw_fire = awvalid && awready;
    assign b_fire  = bvalid && bready;
    // Hit is judged against the bitmap before this cycle's AW set, so a B for
    // the ID being issued in the same cycle counts as unexpected.
    assign b_hit   = b_fire && bitmap[bid];

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (aw_fire) set_mask[awid] = 1'b1;
        if (b_hit)   clr_mask[bid]  = 1'b1;
        bitmap_nxt = (bitmap & ~clr_mask) | set_mask;
        outstanding_nxt = '0;
        for (int i = 0; i < ID_COUNT; i++) begin
            outstanding_nxt = outstanding_nxt + {{ID_WIDTH{1'b0}}, bitmap_nxt[i]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            alloc_req <= 1'b0;
            awvalid   <= 1'b0;
            awid      <= '0;
            awaddr    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (txn_valid && txn_ready) begin
                        awaddr    <= txn_addr;
                        alloc_req <= 1'b1;
                        state     <= S_ALLOC;
                    end
                end
                S_ALLOC: begin
                    if (alloc_valid) begin
                        awid      <= alloc_id;
                        alloc_req <= 1'b0;
                        awvalid   <= 1'b1;
                        state     <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    alloc_req <= 1'b0;
                    awvalid   <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bitmap      <= '0;
            outstanding <= '0;
            dealloc_req <= 1'b0;
            dealloc_id  <= '0;
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_err    <= 1'b0;
            err_bid     <= 1'b0;
        end else begin
            bitmap      <= bitmap_nxt;
            outstanding <= outstanding_nxt;
            dealloc_req <= b_hit;
            resp_valid  <= b_hit;
            if (b_hit) begin
                dealloc_id <= bid;
                resp_id    <= bid;
                resp_err   <= (bresp != 2'b00);
            end
            if (b_fire && !bitmap[bid]) begin
                err_bid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_id_tracker.sv
`timescale 1ns/1ps
module tb_axi_id_tracker;
    localparam int IDW  = 4;
    localparam int IDN  = 16;
    localparam int AW   = 32;
    localparam int MAXO = 16;
    localparam int LIMIT = 40;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           txn_valid, txn_ready;
    logic [AW-1:0]  txn_addr;
    logic           alloc_req, alloc_valid;
    logic [IDW-1:0] alloc_id;
    logic           dealloc_req;
    logic [IDW-1:0] dealloc_id;
    logic           awvalid, awready;
    logic [IDW-1:0] awid;
    logic [AW-1:0]  awaddr;
    logic           bvalid, bready;
    logic [IDW-1:0] bid;
    logic [1:0]     bresp;
    logic           resp_valid;
    logic [IDW-1:0] resp_id;
    logic           resp_err;
    logic [IDW:0]   outstanding;
    logic           err_bid;

    always #5 clk = ~clk;

    axi_id_tracker #(.ID_WIDTH(IDW), .ID_COUNT(IDN), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .reset_n(reset_n),
        .txn_valid(txn_valid), .txn_ready(txn_ready), .txn_addr(txn_addr),
        .alloc_req(alloc_req), .alloc_valid(alloc_valid), .alloc_id(alloc_id),
        .dealloc_req(dealloc_req), .dealloc_id(dealloc_id),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_err(resp_err),
        .outstanding(outstanding), .err_bid(err_bid)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out after %0d cycles t=%0t", name, LIMIT, $time);
    endtask

    // Reference model: set of outstanding IDs, queue of accepted-but-not-issued
    // addresses, and an ID pool that always grants the lowest free ID.
    bit            out_set[IDN];
    int            n_out;
    bit            err_m;
    logic [AW-1:0] addr_q[$];
    bit            granted;
    int            gid;
    bit            pool_used[IDN];
    bit            pool_stall;

    bit             c_txn, c_grant, c_aw, c_b, c_dealloc;
    logic [AW-1:0]  c_addr, c_awaddr;
    logic [IDW-1:0] c_gid, c_bid, c_did, c_awid;
    logic [1:0]     c_bresp;

    task automatic model_reset();
        for (int i = 0; i < IDN; i++) begin
            out_set[i]   = 1'b0;
            pool_used[i] = 1'b0;
        end
        n_out   = 0;
        err_m   = 1'b0;
        granted = 1'b0;
        gid     = 0;
        addr_q.delete();
    endtask

    // One clock: drive the pool, check pre-edge outputs, capture handshakes,
    // advance through the edge, update the model and check registered results.
    task automatic cyc();
        bit busy, exp_r, exp_rerr;
        logic [IDW-1:0] exp_rid;
        alloc_valid = 1'b0;
        alloc_id    = '0;
        if (alloc_req && !pool_stall) begin
            for (int i = IDN-1; i >= 0; i--) begin
                if (!pool_used[i]) begin
                    alloc_valid = 1'b1;
                    alloc_id    = IDW'(i);
                end
            end
        end
        #1;
        busy = (addr_q.size() != 0);
        chk("txn_ready", txn_ready, !busy && (n_out < MAXO));
        chk("alloc_req", alloc_req, busy && !granted);
        chk("awvalid", awvalid, busy && granted);
        chk("bready", bready, 1);
        if (busy && granted) begin
            chk("awid", awid, gid);
            chk("awaddr", awaddr, addr_q[0]);
        end
        c_txn     = txn_valid && !busy && (n_out < MAXO);
        c_addr    = txn_addr;
        c_grant   = alloc_valid;
        c_gid     = alloc_id;
        c_aw      = busy && granted && awready;
        c_awid    = awid;
        c_awaddr  = awaddr;
        c_b       = bvalid;
        c_bid     = bid;
        c_bresp   = bresp;
        c_dealloc = dealloc_req;
        c_did     = dealloc_id;
        @(posedge clk);
        #1;
        exp_r    = 1'b0;
        exp_rid  = '0;
        exp_rerr = 1'b0;
        if (c_b) begin
            if (out_set[c_bid]) begin
                out_set[c_bid] = 1'b0;
                n_out--;
                exp_r    = 1'b1;
                exp_rid  = c_bid;
                exp_rerr = (c_bresp != 2'b00);
            end else begin
                err_m = 1'b1;
            end
        end
        if (c_aw) begin
            if (!out_set[gid]) n_out++;
            out_set[gid] = 1'b1;
            void'(addr_q.pop_front());
            granted = 1'b0;
        end
        if (c_grant) begin
            granted = 1'b1;
            gid = int'(c_gid);
            pool_used[c_gid] = 1'b1;
        end
        if (c_dealloc) pool_used[c_did] = 1'b0;
        if (c_txn) addr_q.push_back(c_addr);
        chk("resp_valid", resp_valid, exp_r);
        chk("dealloc_req", dealloc_req, exp_r);
        if (exp_r) begin
            chk("resp_id", resp_id, exp_rid);
            chk("resp_err", resp_err, exp_rerr);
            chk("dealloc_id", dealloc_id, exp_rid);
        end
        chk("outstanding", outstanding, n_out);
        chk("err_bid", err_bid, err_m);
    endtask

    task automatic do_reset();
        txn_valid = 1'b0;
        bvalid    = 1'b0;
        bid       = '0;
        bresp     = 2'b00;
        reset_n   = 1'b0;
        #2;
        chk("rst_txn_ready", txn_ready, 0);
        chk("rst_bready", bready, 0);
        chk("rst_alloc_req", alloc_req, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_awid", awid, 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_dealloc_req", dealloc_req, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err_bid", err_bid, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        reset_n = 1'b1;
        #1;
        chk("rel_txn_ready", txn_ready, 1);
        chk("rel_bready", bready, 1);
        chk("rel_outstanding", outstanding, 0);
    endtask

    task automatic send_txn(input logic [AW-1:0] addr, output int id_got, output logic [AW-1:0] addr_got);
        int n;
        id_got   = -1;
        addr_got = '0;
        txn_valid = 1'b1;
        txn_addr  = addr;
        n = 0;
        do begin cyc(); n++; end while (!c_txn && n < LIMIT);
        txn_valid = 1'b0;
        if (!c_txn) begin timeout_fail("txn_accept"); return; end
        n = 0;
        do begin cyc(); n++; end while (!c_aw && n < LIMIT);
        if (!c_aw) begin timeout_fail("aw_handshake"); return; end
        id_got   = int'(c_awid);
        addr_got = c_awaddr;
    endtask

    task automatic send_b(input logic [IDW-1:0] id, input logic [1:0] rsp);
        bvalid = 1'b1;
        bid    = id;
        bresp  = rsp;
        cyc();
        bvalid = 1'b0;
    endtask

    typedef struct {
        logic [IDW-1:0] b_id;
        logic [1:0]     b_resp;
        logic           e_resp;
        logic           e_err;
        int             e_out;
        logic           e_errbid;
    } bvec_t;

    bvec_t tbl[6];

    initial begin
        int id;
        int n;
        int k;
        logic [AW-1:0] a;

        tbl[0] = '{4'd3,  2'b10, 1'b1, 1'b1, 15, 1'b0};
        tbl[1] = '{4'd5,  2'b00, 1'b1, 1'b0, 14, 1'b0};
        tbl[2] = '{4'd9,  2'b11, 1'b1, 1'b1, 13, 1'b0};
        tbl[3] = '{4'd9,  2'b00, 1'b0, 1'b0, 13, 1'b1};
        tbl[4] = '{4'd12, 2'b01, 1'b1, 1'b1, 12, 1'b1};
        tbl[5] = '{4'd3,  2'b00, 1'b0, 1'b0, 12, 1'b1};

        reset_n     = 1'b1;
        txn_valid   = 1'b0;
        txn_addr    = '0;
        alloc_valid = 1'b0;
        alloc_id    = '0;
        awready     = 1'b1;
        bvalid      = 1'b0;
        bid         = '0;
        bresp       = 2'b00;
        pool_stall  = 1'b0;
        model_reset();
        #1;
        do_reset();

        // Single transaction through to retirement.
        send_txn(32'h1000, id, a);
        chk("t1_awid", id, 0);
        chk("t1_awaddr", a, 32'h1000);
        chk("t1_outstanding", outstanding, 1);
        send_b(4'd0, 2'b00);
        chk("t1_dealloc_req", dealloc_req, 1);
        chk("t1_dealloc_id", dealloc_id, 0);
        chk("t1_outstanding0", outstanding, 0);

        // Fill every ID, then free one and reuse it.
        for (int i = 0; i < 16; i++) begin
            send_txn(32'h2000 + 32'(i * 16), id, a);
            chk("t2_awid", id, i);
        end
        chk("t2_outstanding", outstanding, 16);
        chk("t2_txn_ready", txn_ready, 0);
        send_b(4'd7, 2'b00);
        chk("t2_dealloc_id", dealloc_id, 7);
        chk("t2_txn_ready_free", txn_ready, 1);
        send_txn(32'h2800, id, a);
        chk("t2_reuse_awid", id, 7);

        // B beats against a full bitmap, including error responses and misses.
        for (int i = 0; i < 6; i++) begin
            send_b(tbl[i].b_id, tbl[i].b_resp);
            chk("tbl_resp_valid", resp_valid, tbl[i].e_resp);
            chk("tbl_dealloc_req", dealloc_req, tbl[i].e_resp);
            if (tbl[i].e_resp) begin
                chk("tbl_resp_id", resp_id, tbl[i].b_id);
                chk("tbl_resp_err", resp_err, tbl[i].e_err);
                chk("tbl_dealloc_id", dealloc_id, tbl[i].b_id);
            end
            chk("tbl_outstanding", outstanding, tbl[i].e_out);
            chk("tbl_err_bid", err_bid, tbl[i].e_errbid);
        end
        for (int i = 0; i < 3; i++) cyc();
        chk("sticky_err_bid", err_bid, 1);

        // AW stalled for 5 cycles, then released together with a B for the same ID.
        do_reset();
        awready   = 1'b0;
        txn_valid = 1'b1;
        txn_addr  = 32'h3000;
        n = 0;
        do begin cyc(); n++; end while (!c_txn && n < LIMIT);
        txn_valid = 1'b0;
        n = 0;
        while (!awvalid && n < LIMIT) begin cyc(); n++; end
        if (!awvalid) timeout_fail("stall_awvalid");
        for (int i = 0; i < 5; i++) begin
            chk("stall_awvalid", awvalid, 1);
            chk("stall_awid", awid, 0);
            chk("stall_awaddr", awaddr, 32'h3000);
            chk("stall_alloc_req", alloc_req, 0);
            chk("stall_txn_ready", txn_ready, 0);
            cyc();
        end
        awready = 1'b1;
        bvalid  = 1'b1;
        bid     = 4'd0;
        bresp   = 2'b00;
        cyc();
        bvalid = 1'b0;
        chk("same_err_bid", err_bid, 1);
        chk("same_outstanding", outstanding, 1);
        chk("same_resp_valid", resp_valid, 0);
        chk("same_dealloc_req", dealloc_req, 0);

        // Reset while in ADDR with 4 outstanding.
        do_reset();
        awready = 1'b1;
        for (int i = 0; i < 4; i++) send_txn(32'h4000 + 32'(i), id, a);
        awready   = 1'b0;
        txn_valid = 1'b1;
        txn_addr  = 32'h5000;
        n = 0;
        do begin cyc(); n++; end while (!c_txn && n < LIMIT);
        txn_valid = 1'b0;
        n = 0;
        while (!awvalid && n < LIMIT) begin cyc(); n++; end
        chk("mid_awvalid", awvalid, 1);
        chk("mid_outstanding", outstanding, 4);
        do_reset();

        // Randomised traffic against the model.
        awready = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!txn_valid && $urandom_range(0, 2) == 0) begin
                txn_valid = 1'b1;
                txn_addr  = $urandom;
            end
            awready    = 1'($urandom_range(0, 1));
            pool_stall = ($urandom_range(0, 3) == 0);
            bvalid     = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                bvalid = 1'b1;
                bresp  = 2'($urandom_range(0, 3));
                if (n_out > 0 && $urandom_range(0, 9) != 0) begin
                    k = $urandom_range(0, n_out - 1);
                    for (int i = 0; i < IDN; i++) begin
                        if (out_set[i]) begin
                            if (k == 0) bid = IDW'(i);
                            k--;
                        end
                    end
                end else begin
                    bid = IDW'($urandom_range(0, IDN - 1));
                end
            end
            cyc();
            if (c_txn) txn_valid = 1'b0;
        end
        bvalid     = 1'b0;
        txn_valid  = 1'b0;
        pool_stall = 1'b0;
        for (int i = 0; i < 5; i++) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
